// File: rtl/mult_accum_pkg.sv
// Shared types and constants for the multiplier accumulator stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_accum_pkg;

    localparam int ACC_W_DEF    = 40;
    localparam int LEN_W_DEF    = 8;
    localparam int MULT_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest signed value representable in w bits, returned in the low w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value representable in w bits, in the low w bits.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/mult_accum_if.sv
// Operand-token and result handshake bundle between mult_accum and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready for operands, acc_valid/acc_ready for the result.
interface mult_accum_if import mult_accum_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      p_in;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    // Upstream/downstream side: drives operands and accepts results.
    modport master (
        output in_valid, p_in, acc_ready,
        input  in_ready, acc_valid, acc_out, ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, p_in, acc_ready,
        output in_ready, acc_valid, acc_out, ovf
    );

endinterface

// File: rtl/mult_accum_vld_delay.sv
// DEPTH-deep 1-bit shift register carrying issue tokens alongside a fixed-latency pipe.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle because the companion pipe cannot stall.
module mult_accum_vld_delay import mult_accum_pkg::*; #(
    parameter int DEPTH = MULT_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            // Single stage: register the token directly.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= d;
            end
        end else begin : g_many
            // Shift the token toward the MSB once per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/mult_accum.sv
// Accumulates len signed 32-bit products from mult_top into a saturating ACC_W-bit sum.
// Latency: N + MULT_LAT cycles from start to acc_valid with continuous operands.
// Backpressure: in_ready gates operand issue; result held in DONE until acc_ready.
module mult_accum import mult_accum_pkg::*; #(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    mult_accum_if.slave      acc_if,
    output logic             busy
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf_q;
    logic [LEN_W-1:0] issue_cnt;
    logic [LEN_W-1:0] recv_cnt;
    logic [LEN_W-1:0] len_q;

    logic             tok;
    logic             p_vld;
    logic [ACC_W:0]   sum;
    logic             sat_hit;
    logic [ACC_W-1:0] sat_val;

    assign tok = acc_if.in_valid & acc_if.in_ready;

    // Token rides alongside the multiplier pipe so p_vld marks products of this run.
    mult_accum_vld_delay #(.DEPTH(MULT_LAT)) u_vld_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tok),
        .q     (p_vld)
    );

    // Widen by one bit so the carry-out exposes signed overflow, then clamp.
    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W-31){acc_if.p_in[31]}}, acc_if.p_in};
        sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
        sat_val = sum[ACC_W-1:0];
        if (sat_hit) sat_val = sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: the run ends on the edge that registers the final product.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (p_vld && (recv_cnt + LEN_W'(1) == len_q)) state_nxt = DONE;
            end
            DONE: begin
                if (acc_if.acc_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; issue stops once len_q tokens have gone out.
    always_comb begin
        acc_if.in_ready  = 1'b0;
        acc_if.acc_valid = 1'b0;
        busy             = (state != IDLE);
        case (state)
            ACCUM:   acc_if.in_ready  = (issue_cnt != len_q);
            DONE:    acc_if.acc_valid = 1'b1;
            default: ;
        endcase
    end

    assign acc_if.acc_out = acc;
    assign acc_if.ovf     = ovf_q;

    // Run setup on accepted start; counting and saturating accumulation during ACCUM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf_q     <= 1'b0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            len_q     <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                len_q     <= len;
                acc       <= '0;
                ovf_q     <= 1'b0;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
        end else if (state == ACCUM) begin
            if (tok) issue_cnt <= issue_cnt + LEN_W'(1);
            if (p_vld) begin
                acc      <= sat_val;
                recv_cnt <= recv_cnt + LEN_W'(1);
                if (sat_hit) ovf_q <= 1'b1;
            end
        end
    end

    // A product token outside a run means the delay line and FSM disagree.
    p_vld_in_run: assert property (@(posedge clk) disable iff (!rst_n) p_vld |-> state == ACCUM);

endmodule

// File: tb/tb_mult_accum.sv
// Scoreboard bench for mult_accum at 40-bit and 32-bit accumulator widths in lockstep.
// Latency: checks start-to-acc_valid cycle counts against the expected pipeline depth.
// Backpressure: exercises gapped in_valid, stray in_valid past len, and held acc_ready.
module tb_mult_accum;
    import mult_accum_pkg::*;

    localparam logic [31:0] GARB = 32'h0BAD_0BAD;

    typedef struct {
        longint acc;
        bit     ovf;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] len    = 8'd0;
    logic       busy40;
    logic       busy32;

    logic [31:0] cur_prod = GARB;
    logic [31:0] pipe1    = 32'd0;
    logic [31:0] pipe2    = 32'd0;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   prods [256];
    exp_t q40 [$];
    exp_t q32 [$];
    exp_t m40, m32;

    mult_accum_if #(.ACC_W(40)) if40 ();
    mult_accum_if #(.ACC_W(32)) if32 ();

    mult_accum #(.ACC_W(40), .LEN_W(8), .MULT_LAT(2)) dut40 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len),
        .acc_if (if40.slave),
        .busy   (busy40)
    );

    mult_accum #(.ACC_W(32), .LEN_W(8), .MULT_LAT(2)) dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len),
        .acc_if (if32.slave),
        .busy   (busy32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unreset two-stage stand-in for mult_top: whatever is presented reappears two edges later.
    always @(posedge clk) begin
        pipe1 <= cur_prod;
        pipe2 <= pipe1;
    end

    assign if40.p_in      = pipe2;
    assign if32.p_in      = pipe2;
    assign if32.in_valid  = if40.in_valid;
    assign if32.acc_ready = if40.acc_ready;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference sum of the first n entries of prods, clamped to a w-bit signed range.
    function automatic exp_t model(input int n, input int w);
        exp_t   r;
        longint mx, mn, s;
        mx    = (longint'(1) <<< (w - 1)) - 1;
        mn    = -(longint'(1) <<< (w - 1));
        r.acc = 0;
        r.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = r.acc + longint'(prods[i]);
            if (s > mx) begin s = mx; r.ovf = 1'b1; end
            if (s < mn) begin s = mn; r.ovf = 1'b1; end
            r.acc = s;
        end
        return r;
    endfunction

    // Result monitors: pop the scoreboard on every completed result handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n && if40.acc_valid && if40.acc_ready) begin
            if (q40.size() == 0) check("sb40_extra", q40.size(), 1);
            else begin
                m40 = q40.pop_front();
                check("sb40_acc", $signed(if40.acc_out), m40.acc);
                check("sb40_ovf", if40.ovf, m40.ovf);
            end
        end
        if (rst_n && if32.acc_valid && if32.acc_ready) begin
            if (q32.size() == 0) check("sb32_extra", q32.size(), 1);
            else begin
                m32 = q32.pop_front();
                check("sb32_acc", $signed(if32.acc_out), m32.acc);
                check("sb32_ovf", if32.ovf, m32.ovf);
            end
        end
    end

    // One run: pat gives in_valid per cycle for the first patlen cycles, then continuous.
    task automatic run(input int n, input bit [15:0] pat, input int patlen, input int exp_lat);
        int idx, k, t0, g;
        bit v;
        q40.push_back(model(n, 40));
        q32.push_back(model(n, 32));
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        idx   = 0;
        k     = 0;
        while (idx < n && k < 2000) begin
            v             = (k < patlen) ? pat[k] : 1'b1;
            if40.in_valid = v;
            cur_prod      = v ? prods[idx] : GARB;
            if (v && if40.in_ready) idx++;
            k++;
            @(negedge clk);
        end
        check("in_ready_after_last", if40.in_ready, 0);
        g = 0;
        while (!if40.acc_valid && g < 600) begin
            if40.in_valid = (g < 2);
            cur_prod      = GARB;
            if (if40.in_ready) check("in_ready_stray", if40.in_ready, 0);
            g++;
            @(negedge clk);
        end
        if40.in_valid = 1'b0;
        cur_prod      = GARB;
        check("acc_valid_seen", if40.acc_valid, 1);
        check("acc_valid32_seen", if32.acc_valid, 1);
        check("latency", cyc - t0, exp_lat);
        if (if40.acc_ready) begin
            @(negedge clk);
            check("valid_pulse", if40.acc_valid, 0);
            check("idle_busy", busy40, 0);
        end
    endtask

    initial begin
        if40.in_valid  = 1'b0;
        if40.acc_ready = 1'b1;

        @(negedge clk);
        check("rst_acc_valid", if40.acc_valid, 0);
        check("rst_in_ready", if40.in_ready, 0);
        check("rst_busy", busy40, 0);
        check("rst_acc_out", $signed(if40.acc_out), 0);
        check("rst_ovf", if40.ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic back-to-back run and the empty run.
        prods[0] = 100; prods[1] = 200; prods[2] = -50; prods[3] = 7;
        run(4, 16'h0, 0, 6);
        run(0, 16'h0, 0, 0);

        // Large positives: exact at 40 bits, saturating at 32 bits.
        for (int i = 0; i < 3; i++) prods[i] = 32'h7FFF_FFFF;
        run(3, 16'h0, 0, 5);
        prods[0] = 32'h7FFF_FFFF; prods[1] = 1; prods[2] = -1;
        run(3, 16'h0, 0, 5);
        prods[0] = 32'h8000_0000; prods[1] = -1;
        run(2, 16'h0, 0, 4);

        // Gapped in_valid 1,0,1,1,0,1 with stray valids after the fourth token.
        prods[0] = 11; prods[1] = -22; prods[2] = 33; prods[3] = -44;
        run(4, 16'b101101, 6, 8);

        // Result held for five cycles with a start pulse that must be ignored.
        if40.acc_ready = 1'b0;
        prods[0] = 5; prods[1] = 6;
        run(2, 16'h0, 0, 4);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd1;
            @(negedge clk);
            check("hold_valid", if40.acc_valid, 1);
            check("hold_acc", $signed(if40.acc_out), q40[0].acc);
        end
        start          = 1'b1;
        if40.acc_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hs_start_ignored", busy40, 0);
        check("hs_valid_drop", if40.acc_valid, 0);

        // Reset with two products in flight, then a fresh single-term run.
        prods[0] = 41; prods[1] = 42; prods[2] = 43; prods[3] = 44;
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if40.in_valid = 1'b1;
            cur_prod      = prods[i];
            @(negedge clk);
        end
        rst_n         = 1'b0;
        if40.in_valid = 1'b0;
        cur_prod      = GARB;
        #1;
        check("midrst_busy", busy40, 0);
        check("midrst_busy32", busy32, 0);
        check("midrst_acc_out", $signed(if40.acc_out), 0);
        check("midrst_in_ready", if40.in_ready, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        prods[0] = 9;
        run(1, 16'h0, 0, 3);

        // Maximum length: no counter wrap; extreme negatives saturate only at 32 bits.
        for (int i = 0; i < 255; i++) prods[i] = int'($urandom);
        run(255, 16'h0, 0, 257);
        for (int i = 0; i < 255; i++) prods[i] = 32'h8000_0000;
        run(255, 16'h0, 0, 257);

        repeat (3) @(negedge clk);
        check("sb40_left", q40.size(), 0);
        check("sb32_left", q32.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Downstream consumer of the registered 16x16 approximate-multiplier top.
- Issues operand-valid tokens alongside the x/y operands. Delays those tokens to line up with the multiplier's fixed 2-cycle product latency. Accumulates a programmed number of signed 32-bit products into a saturating ACC_W-bit sum.
- Presents the sum on a valid/ready output handshake. Used for dot-product and error-statistics runs over the approximate multiplier.

Parameters:
ACC_W, 40, accumulator/result width in bits (>= 32)
LEN_W, 8, width of the term-count field
MULT_LAT, 2, cycles from operands presented to mult_top until the matching p_out is valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse, begins a run; honoured only in IDLE
len  in  LEN_W  number of products to accumulate; sampled on accepted start
in_valid  in  1  upstream drives a valid x/y pair to mult_top this cycle
in_ready  out  1  block accepts an operand pair this cycle
p_in  in  32  mult_top p_out, signed two's complement
acc_valid  out  1  result available
acc_ready  in  1  downstream accepts result
acc_out  out  ACC_W  signed accumulated sum
ovf  out  1  sum saturated at least once during the run; valid with acc_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, issue_cnt=0, recv_cnt=0, len_q=0.
  - Valid delay line all 0; ovf=0, acc_valid=0, in_ready=0, busy=0; acc_out=0.
- Issue token: tok = in_valid & in_ready. A MULT_LAT-deep shift register carries tok. Its output p_vld marks p_in as a product belonging to the current run. The shift register shifts every cycle, with no stall, because mult_top cannot stall.
- FSM states:
  - IDLE: in_ready=0. On start: len_q<=len, acc<=0, ovf<=0, counters<=0. If len==0 go DONE with acc=0; else go ACCUM.
  - ACCUM: in_ready = (issue_cnt != len_q). tok increments issue_cnt. p_vld adds sign-extended p_in into acc and increments recv_cnt. When recv_cnt reaches len_q, go DONE. Reaching it means the add that makes recv_cnt==len_q has been registered.
  - DONE: acc_valid=1, acc_out and ovf held stable. When acc_valid & acc_ready, go IDLE next cycle and drop acc_valid.
- Latency:
  - Last operand issued at cycle t → its product is added at edge t+MULT_LAT.
  - acc_valid rises the cycle after that edge.
  - With continuous in_valid, a run of N terms yields acc_valid N+MULT_LAT cycles after start, excluding the start cycle.
- Arithmetic:
  - sum = acc + sext(p_in) computed at ACC_W+1 bits.
  - If the sum exceeds the signed ACC_W range, clamp to max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) and set ovf sticky.
  - Subsequent adds continue from the clamped value.
- Boundaries:
  - start outside IDLE is ignored. start in the same cycle as the DONE handshake is ignored, because state is still DONE.
  - in_valid while in_ready=0 is not a token. Upstream must not assume it was consumed.
  - issue_cnt never exceeds len_q. len = 2^LEN_W-1 must work without counter wrap.
  - A p_vld arriving in IDLE or DONE is impossible by construction. The checker flags it as an assertion failure.
  - Reset mid-run clears the delay line, so products still in mult_top's unreset pipeline are discarded.
  - acc_ready held high before DONE has no effect.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCUM, DONE), MULT_LAT default, ACC_W default, and saturation max/min constant functions of ACC_W.
- One natural sub-module: vld_delay (parameterised MULT_LAT-deep 1-bit shift register, async active-low clear), reusable for other stages that wrap mult_top.
- The FSM, counters and saturating adder stay in mult_accum.

Test Plan:
- len=4, products 100,200,-50,7 back-to-back, acc_ready=1 → acc_out=257, ovf=0, acc_valid exactly 1 cycle, rising 6 cycles after start.
- len=0 → acc_valid the cycle after start, acc_out=0, in_ready never high.
- ACC_W=40, len=3, products 0x7FFFFFFF ×3 → exact sum 0x17FFFFFFD; no saturation, ovf=0. Then a forced acc preload near max with product +1 → acc_out=2^39-1, ovf=1.
- in_valid toggled 1,0,1,1,0,1 with len=4 → exactly 4 tokens counted; in_ready drops after the 4th; result equals the sum of those 4 products only.
- Hold acc_ready=0 for 5 cycles in DONE, pulse start meanwhile → acc_out stable, start ignored, IDLE one cycle after the acc_ready handshake.
- Assert rst_n=0 mid-ACCUM with 2 products in flight, release, start len=1, product 9 → acc_out=9; stale products not added.
